// File: rtl/mbssoc_pkg.sv
// ============================================================================
// Package  : mbssoc_pkg
// Desc     : Shared arbiter state encoding, bus ctrl bit indices, default widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mbssoc_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    localparam int CTRL_RE = 0;
    localparam int CTRL_WE = 1;

    localparam int DEF_NUM_MST     = 2;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_CTRL_W      = 2;
    localparam int DEF_TIMEOUT_CYC = 16;

    // Index of the set bit in a one-hot vector of up to 8 masters.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mbssoc_rr_picker.sv
// ============================================================================
// Module   : mbssoc_rr_picker
// Desc     : Combinational round-robin pick: first set req at or above start, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mbssoc_rr_picker
    import mbssoc_pkg::*;
#(
    parameter int NUM_MST = DEF_NUM_MST,
    parameter int PTR_W   = $clog2(DEF_NUM_MST)
) (
    input  logic [NUM_MST-1:0] req,
    input  logic [PTR_W-1:0]   start,
    output logic [NUM_MST-1:0] winner,
    output logic               valid
);

    logic [NUM_MST-1:0] w_at_or_above;
    logic [NUM_MST-1:0] w_hi_req;
    logic [NUM_MST-1:0] w_first_hi;
    logic [NUM_MST-1:0] w_first_all;

    // Requests at or above the pointer win first; otherwise wrap to the lowest request.
    assign w_at_or_above = ~((NUM_MST'(1) << start) - NUM_MST'(1));
    assign w_hi_req      = req & w_at_or_above;
    assign w_first_hi    = w_hi_req & (~w_hi_req + NUM_MST'(1));
    assign w_first_all   = req & (~req + NUM_MST'(1));

    assign winner = (|w_hi_req) ? w_first_hi : w_first_all;
    assign valid  = |req;

endmodule

`default_nettype wire

// File: rtl/mbssoc_bus_arbiter.sv
// ============================================================================
// Module   : mbssoc_bus_arbiter
// Desc     : Round-robin owner arbitration and mux of the shared SoC system bus.
// Config   : ARB_TIMEOUT_EN - revoke a grant held TIMEOUT_CYC cycles while others wait.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mbssoc_bus_arbiter
    import mbssoc_pkg::*;
#(
    parameter int NUM_MST     = DEF_NUM_MST,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CTRL_W      = DEF_CTRL_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_MST-1:0]          req,
    input  logic [NUM_MST*ADDR_W-1:0]   m_addr,
    input  logic [NUM_MST*CTRL_W-1:0]   m_ctrl,
    input  logic [NUM_MST*DATA_W-1:0]   m_wdata,
    output logic [NUM_MST-1:0]          grant,
    output logic [$clog2(NUM_MST)-1:0]  owner,
    output logic                        busy,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [CTRL_W-1:0]           bus_ctrl,
    output logic [DATA_W-1:0]           bus_wdata,
    output logic                        timeout_evt
);

    localparam int OWN_W = $clog2(NUM_MST);

    arb_state_t         r_state, w_state_nxt;
    logic [NUM_MST-1:0] r_grant, w_grant_nxt;
    logic [OWN_W-1:0]   r_owner, w_owner_nxt;
    logic [OWN_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [OWN_W-1:0]   w_owner_inc;
    logic [OWN_W-1:0]   w_pick_start;
    logic [NUM_MST-1:0] w_pick_mask;
    logic [NUM_MST-1:0] w_pick_win;
    logic [OWN_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic               w_revoke;
    logic               w_handover;

    assign w_owner_inc  = (r_owner == OWN_W'(NUM_MST - 1)) ? '0 : r_owner + OWN_W'(1);
    // While owning, the search starts past the owner and excludes it, so a revoke never re-picks it.
    assign w_pick_start = (r_state == ARB_OWN) ? w_owner_inc : r_rr_ptr;
    assign w_pick_mask  = req & ~r_grant;
    assign w_handover   = (r_state == ARB_OWN) && (!req[r_owner] || w_revoke);

    mbssoc_rr_picker #(
        .NUM_MST (NUM_MST),
        .PTR_W   (OWN_W)
    ) u_picker (
        .req    (w_pick_mask),
        .start  (w_pick_start),
        .winner (w_pick_win),
        .valid  (w_pick_valid)
    );

    assign w_pick_idx = OWN_W'(onehot_to_idx(8'(w_pick_win)));

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ARB_OWN;
                    w_grant_nxt = w_pick_win;
                    w_owner_nxt = w_pick_idx;
                end
            end
            ARB_OWN: begin
                if (w_handover) begin
                    w_rr_nxt = w_owner_inc;
                    if (w_pick_valid) begin
                        w_grant_nxt = w_pick_win;
                        w_owner_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                        w_grant_nxt = '0;
                        w_owner_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
                w_owner_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_timeout_evt;
    logic             w_others;

    assign w_others = |(req & ~r_grant);
    assign w_revoke = (r_state == ARB_OWN) && req[r_owner] && w_others &&
                      (r_hold_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt    <= '0;
            r_timeout_evt <= 1'b0;
        end else begin
            r_timeout_evt <= w_revoke;
            if ((r_state != ARB_OWN) || w_handover || !w_others) begin
                r_hold_cnt <= '0;
            end else begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
        end
    end

    assign timeout_evt = r_timeout_evt;
`else
    assign w_revoke    = 1'b0;
    assign timeout_evt = 1'b0;

    if (TIMEOUT_CYC < 2) begin : g_timeout_unused
    end
`endif

    // AND-OR mux on the registered one-hot grant; an idle bus presents all zeros.
    always_comb begin
        bus_addr  = '0;
        bus_ctrl  = '0;
        bus_wdata = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (r_grant[i]) begin
                bus_addr  = bus_addr  | m_addr[i*ADDR_W +: ADDR_W];
                bus_ctrl  = bus_ctrl  | m_ctrl[i*CTRL_W +: CTRL_W];
                bus_wdata = bus_wdata | m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant = r_grant;
    assign owner = r_owner;
    assign busy  = (r_state == ARB_OWN);

endmodule

`default_nettype wire
